// File: rtl/oclib_bc_pkg.sv
// Shared types and helpers for byte-channel (BC) blocks: the BC link struct,
// the arbiter state encoding and length-byte decoding.
package oclib_bc_pkg;

    // One direction pair of a byte channel: data/valid flow one way, ready the other.
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bc_8b_bidi_s;

    // Largest message a single length byte can describe.
    localparam int BcMaxLength = 256;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LEN,
        REQ,
        WAIT_RSP,
        RSP
    } arbStateE;

    // Bytes still to come after the length byte itself; 0 encodes a full-size message.
    function automatic logic [7:0] decodeLength(input logic [7:0] lengthByte);
        if (lengthByte == 8'd0) return 8'(BcMaxLength - 1);
        return lengthByte - 8'd1;
    endfunction

endpackage

// File: rtl/oclib_rr_arbiter.sv
// Combinational round-robin pick: the first active request at or after the
// pointer (wrapping) wins. One-hot result, all zero when nothing requests.
module oclib_rr_arbiter #(
    parameter int Requesters = 2,
    parameter int PtrWidth   = (Requesters > 1) ? $clog2(Requesters) : 1
) (
    input  logic [Requesters-1:0] request,
    input  logic [PtrWidth-1:0]   pointer,
    output logic [Requesters-1:0] grant
);

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch can never be inferred.
        grant = '0;
        for (int k = 0; k < Requesters; k++) begin
            if (grant == '0 && request[(int'(pointer) + k) % Requesters]) begin
                grant[(int'(pointer) + k) % Requesters] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oc_bc_arbiter.sv
// Shares one downstream BC target among several BC masters. A master owns the
// target for one length-prefixed request plus its matching response; a silent
// target is released after a timeout and the event is flagged sticky.
module oc_bc_arbiter
    import oclib_bc_pkg::*;
#(
    parameter int  Requesters    = 2,
    parameter int  TimeoutCycles = 1_000_000,
    parameter type BcType        = bc_8b_bidi_s
) (
    input  logic                  clock,
    input  logic                  reset,
    input  BcType                 upIn [Requesters],
    output BcType                 upOut [Requesters],
    output BcType                 downOut,
    input  BcType                 downIn,
    output logic [Requesters-1:0] grant,
    output logic                  busy,
    output logic                  timeoutError,
    input  logic                  errorClear
);

    localparam int PtrWidth   = (Requesters > 1) ? $clog2(Requesters) : 1;
    localparam int TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam bit TimeoutEnabled = (TimeoutCycles != 0);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

    arbStateE                state, stateNext;
    logic [Requesters-1:0]   grantQ, grantNext;
    logic [Requesters-1:0]   requestVec, pick;
    logic [PtrWidth-1:0]     rrPointer, rrPointerNext;
    logic [PtrWidth-1:0]     owner, ownerNext, winnerIdx;
    logic [7:0]              byteCount, byteCountNext;
    logic [TimerWidth-1:0]   timer, timerNext;
    logic                    timeoutErrorNext;
    logic                    reqXfer, rspXfer, timerExpired;

    // Collect request lines and convert the one-hot pick into an owner index.
    always_comb begin
        requestVec = '0;
        winnerIdx  = '0;
        for (int i = 0; i < Requesters; i++) begin
            requestVec[i] = upIn[i].valid;
            if (pick[i]) winnerIdx = PtrWidth'(i);
        end
    end

    oclib_rr_arbiter #(
        .Requesters(Requesters),
        .PtrWidth  (PtrWidth)
    ) uRrArbiter (
        .request(requestVec),
        .pointer(rrPointer),
        .grant  (pick)
    );

    // Zero-latency mux steered by the registered owner; idle swallows stray response bytes.
    always_comb begin
        for (int i = 0; i < Requesters; i++) upOut[i] = '0;
        downOut = '0;
        reqXfer = 1'b0;
        rspXfer = 1'b0;
        case (state)
            IDLE: downOut.ready = 1'b1;
            REQ_LEN, REQ: begin
                downOut.data        = upIn[owner].data;
                downOut.valid       = upIn[owner].valid;
                upOut[owner].ready  = downIn.ready;
                reqXfer             = upIn[owner].valid && downIn.ready;
            end
            WAIT_RSP, RSP: begin
                upOut[owner].data   = downIn.data;
                upOut[owner].valid  = downIn.valid;
                downOut.ready       = upIn[owner].ready;
                rspXfer             = downIn.valid && upIn[owner].ready;
            end
            default: ;
        endcase
    end

    assign timerExpired = TimeoutEnabled && (timer == TimerLast);

    // Next-state logic: grant, message byte counting, timeout and sticky error.
    always_comb begin
        stateNext        = state;
        grantNext        = grantQ;
        ownerNext        = owner;
        rrPointerNext    = rrPointer;
        byteCountNext    = byteCount;
        timeoutErrorNext = timeoutError;
        if (errorClear) timeoutErrorNext = 1'b0;
        case (state)
            IDLE: begin
                if (|pick) begin
                    grantNext     = pick;
                    ownerNext     = winnerIdx;
                    rrPointerNext = PtrWidth'((int'(winnerIdx) + 1) % Requesters);
                    stateNext     = REQ_LEN;
                end
            end
            REQ_LEN: begin
                if (reqXfer) begin
                    byteCountNext = decodeLength(upIn[owner].data);
                    stateNext     = (byteCountNext == 8'd0) ? WAIT_RSP : REQ;
                end
            end
            REQ: begin
                if (reqXfer) begin
                    byteCountNext = byteCount - 8'd1;
                    if (byteCount == 8'd1) stateNext = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response byte arriving on the expiry cycle still wins.
                if (rspXfer) begin
                    byteCountNext = decodeLength(downIn.data);
                    if (byteCountNext == 8'd0) begin
                        stateNext = IDLE;
                        grantNext = '0;
                    end else begin
                        stateNext = RSP;
                    end
                end else if (timerExpired) begin
                    timeoutErrorNext = 1'b1;
                    grantNext        = '0;
                    stateNext        = IDLE;
                end
            end
            RSP: begin
                if (rspXfer) begin
                    byteCountNext = byteCount - 8'd1;
                    if (byteCount == 8'd1) begin
                        stateNext = IDLE;
                        grantNext = '0;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        // The timer restarts on every state entry and only runs while awaiting a response.
        if (stateNext != state)    timerNext = '0;
        else if (state == WAIT_RSP) timerNext = timer + TimerWidth'(1);
        else                        timerNext = '0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            grantQ       <= '0;
            owner        <= '0;
            rrPointer    <= '0;
            byteCount    <= '0;
            timer        <= '0;
            timeoutError <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
            state        <= stateNext;
            grantQ       <= grantNext;
            owner        <= ownerNext;
            rrPointer    <= rrPointerNext;
            byteCount    <= byteCountNext;
            timer        <= timerNext;
            timeoutError <= timeoutErrorNext;
        end
    end

    assign grant = grantQ;
    assign busy  = (state != IDLE);

endmodule

// File: doc/oc_bc_arbiter.md
Name: oc_bc_arbiter

Overview:
- Shares one downstream byte-channel (BC) target among several BC masters, e.g. UART control, JTAG and PCIe feeding a single csr_adapter and csr_tree.
- Messages are length-prefixed in both directions. The first byte is the total length and includes the length byte itself; a value of 0 means 256.
- Grants one requester at a time, round-robin. The grant is held for one request plus its matching response, so transactions never interleave.
- A response timeout frees the target if it never answers.

Parameters:
- Requesters, 2: number of upstream BC masters (1..8).
- TimeoutCycles, 1_000_000: cycles to wait for the response length byte after the request completes. 0 disables the timeout.
- BcType, oclib_pkg::bc_8b_bidi_s: BC struct type with fields data[7:0], valid, ready.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous assert, active-low; low = in reset.
- upIn[Requesters]  in  BcType  per master: data/valid = request bytes; ready = master can take response bytes.
- upOut[Requesters]  out  BcType  per master: data/valid = response bytes; ready = arbiter accepts request bytes.
- downOut  out  BcType  to target: data/valid = request bytes; ready = arbiter accepts response bytes.
- downIn  in  BcType  from target: data/valid = response bytes; ready = target accepts request bytes.
- grant  out  Requesters  one-hot current owner; all zero when idle.
- busy  out  1  high in any state other than IDLE.
- timeoutError  out  1  sticky; set on timeout.
- errorClear  in  1  synchronous clear of timeoutError.

Behaviour:
- Reset values: state=IDLE, grant=0, rrPointer=0, byteCount=0, timer=0, timeoutError=0. All upOut valid/ready=0, downOut.valid=0, downOut.ready=1.
- Datapath is a combinational mux steered by the registered grant. There are no buffers and zero latency; a byte transfers when valid && ready on the same cycle.
- IDLE:
  - The requester is each master with upIn[i].valid high.
  - Round-robin search starts at rrPointer. The winner is registered, so grant becomes valid the next cycle.
  - On that registration, rrPointer <= winner+1 mod Requesters and state -> REQ_LEN.
  - While IDLE, downOut.ready=1 and any stray downstream bytes are accepted and discarded.
- REQ_LEN:
  - The granted master's stream is forwarded to downOut, and upOut[g].ready = downIn.ready.
  - On the length-byte transfer: byteCount <= len-1 (0 decodes as 256, giving 255).
  - If byteCount would be 0, go to WAIT_RSP; otherwise go to REQ.
- REQ: forward bytes, decrement byteCount per transfer, and go to WAIT_RSP after the last one.
- WAIT_RSP:
  - Timer increments each cycle and downOut.ready = upIn[g].ready.
  - On the response length-byte transfer: forward it to upOut[g], load byteCount the same way, and go to RSP, or to IDLE if byteCount is 0.
  - If TimeoutCycles != 0 and timer reaches TimeoutCycles-1 with no transfer: set timeoutError, clear grant, go to IDLE. No bytes are sent to the master.
  - If a transfer and the expiry occur on the same cycle, the transfer wins.
- RSP: forward response bytes to upOut[g], decrement byteCount per transfer, and go to IDLE after the last one, with grant cleared.
- The timer clears on every state entry. Non-granted masters always see upOut.valid=0 and ready=0.
- Returning to IDLE costs one bubble cycle before the next grant.
- errorClear and a simultaneous timeout: set wins.
- Reset asserted mid-message:
  - All state returns to reset values asynchronously.
  - Partial messages are abandoned; there is no recovery beyond the downstream discard in IDLE.
- A single requester is always granted, i.e. round-robin degenerates to a fixed owner.

Decomposition:
- oclib_bc_pkg holds:
  - the state enum (IDLE, REQ_LEN, REQ, WAIT_RSP, RSP);
  - a function decoding a length byte to a remaining count (0 -> 255);
  - the constant BcMaxLength=256.
- One sub-module, oclib_rr_arbiter, handles the combinational round-robin pick: Requesters wide, pointer in, one-hot grant out. It is reusable elsewhere.

Test Plan:
- Single master 0 sends {09,01..08}; target replies {06,0A..0E} -> downstream sees 9 bytes in order; master 0 receives 6 bytes; grant=01 throughout, then 00; busy drops after the last byte.
- Masters 0 and 1 both request on the same cycle, 3 rounds of {02,AA} with reply {02,55} -> grant order 0,1,0,1,0,1; no byte interleaving on downOut.
- Master 1 holds valid with rrPointer=1 while master 0 is also requesting -> master 1 is granted first; afterwards rrPointer=0.
- TimeoutCycles=100, target silent after request {03,11,22} -> timeoutError=1 exactly 100 cycles after the last request byte; grant=00. A late reply {02,77} is discarded and reaches no master. errorClear pulse -> timeoutError=0.
- Length 00 request (256 bytes) with backpressure: downIn.ready toggles every other cycle -> all 256 bytes delivered, no drops or duplicates; byteCount wrap is correct.
- Reset pulsed low mid-REQ after 4 of 9 bytes -> all outputs at reset values immediately; a subsequent clean transaction passes.
